rectangle_lines_generator: RTL and testbench

Streaming coordinate generator that emits the points of a rectangle's outline, one (x, y) pair per clock, in a fixed order. It is a hardware implementation of a Python generator: a `_start` pulse latches the corner and size, the block yields pairs, then raises `_done`. It sits between a parameter source and a pixel/line consumer that samples `_out0/_out1` when `_valid` is high.

---
 rtl/rectangle_lines_generator_pkg.sv | 13 +
 rtl/rectangle_lines_generator_if.sv | 24 ++
 rtl/rectangle_lines_generator.sv | 143 ++++++++++++++
 tb/tb_rectangle_lines_generator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rectangle_lines_generator_pkg.sv
// Shared types for the rectangle outline point generator.
package rectangle_lines_pkg;

  typedef logic signed [31:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_W_LOOP = 2'd1,
    ST_H_LOOP = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rectangle_lines_generator_if.sv
// Request/stream bundle between the parameter source and the point generator.
interface rectangle_lines_generator_if;
  import rectangle_lines_pkg::*;

  logic  _start;
  data_t s_x;
  data_t s_y;
  data_t height;
  data_t width;
  data_t _out0;
  data_t _out1;
  logic  _valid;
  logic  _done;

  modport master (
    output _start, s_x, s_y, height, width,
    input  _out0, _out1, _valid, _done
  );

  modport slave (
    input  _start, s_x, s_y, height, width,
    output _out0, _out1, _valid, _done
  );
endinterface

// File: rtl/rectangle_lines_generator.sv
// Emits the outline points of a rectangle, one (x, y) pair per clock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for _start after reset
// ST_W_LOOP | width loop: left point (phase 0), right point (phase 1)
// ST_H_LOOP | height loop: top point (phase 0), bottom point (phase 1)
// ST_DONE   | sequence finished, _done held until the next _start
//
// When a loop is exhausted its state falls straight through to the next
// loop's work in the same cycle, so the stream has no bubbles and an empty
// rectangle reports _done one cycle after _start.
module rectangle_lines_generator
  import rectangle_lines_pkg::*;
(
  input logic                        _clock,
  input logic                        _reset_n,
  rectangle_lines_generator_if.slave bus
);

  state_e state_q, state_d;
  data_t  sx_q, sx_d;
  data_t  sy_q, sy_d;
  data_t  h_q, h_d;
  data_t  w_q, w_d;
  data_t  xr_q, xr_d;
  data_t  yb_q, yb_d;
  data_t  cnt_q, cnt_d;
  logic   phase_q, phase_d;
  data_t  out0_q, out0_d;
  data_t  out1_q, out1_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;

  logic   do_h;
  data_t  h_cnt;
  logic   h_phase;

  // Next-state and datapath: latch on start, walk width loop then height loop.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    h_d     = h_q;
    w_d     = w_q;
    xr_d    = xr_q;
    yb_d    = yb_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    valid_d = 1'b0;
    done_d  = done_q;
    do_h    = 1'b0;
    h_cnt   = cnt_q;
    h_phase = phase_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus._start) begin
          sx_d    = bus.s_x;
          sy_d    = bus.s_y;
          h_d     = bus.height;
          w_d     = bus.width;
          xr_d    = bus.s_x + bus.height - data_t'(1);
          yb_d    = bus.s_y + bus.width - data_t'(1);
          cnt_d   = '0;
          phase_d = 1'b0;
          done_d  = 1'b0;
          state_d = ST_W_LOOP;
        end
      end
      ST_W_LOOP: begin
        if (cnt_q < w_q) begin
          out0_d  = phase_q ? xr_q : sx_q;
          out1_d  = sy_q + cnt_q;
          valid_d = 1'b1;
          phase_d = ~phase_q;
          if (phase_q) cnt_d = cnt_q + data_t'(1);
        end else begin
          do_h    = 1'b1;
          h_cnt   = '0;
          h_phase = 1'b0;
          state_d = ST_H_LOOP;
        end
      end
      ST_H_LOOP: do_h = 1'b1;
      default:   state_d = ST_IDLE;
    endcase

    if (do_h) begin
      if (h_cnt < h_q) begin
        out0_d  = sx_q + h_cnt;
        out1_d  = h_phase ? yb_q : sy_q;
        valid_d = 1'b1;
        phase_d = ~h_phase;
        cnt_d   = h_phase ? h_cnt + data_t'(1) : h_cnt;
      end else begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  // State and output registers; reset dominates any concurrent start.
  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      h_q     <= '0;
      w_q     <= '0;
      xr_q    <= '0;
      yb_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      h_q     <= h_d;
      w_q     <= w_d;
      xr_q    <= xr_d;
      yb_q    <= yb_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus._out0  = out0_q;
  assign bus._out1  = out1_q;
  assign bus._valid = valid_q;
  assign bus._done  = done_q;

endmodule

// File: tb/tb_rectangle_lines_generator.sv
// Directed bench for the rectangle outline point generator.
module tb_rectangle_lines_generator;
  import rectangle_lines_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  rectangle_lines_generator_if bus();

  rectangle_lines_generator dut (
    ._clock   (clk),
    ._reset_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int    vecs = 0;
  int    errs = 0;
  data_t exp_x[$];
  data_t exp_y[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected stream straight from the outline formula.
  task automatic build(input data_t sx, input data_t sy, input data_t h, input data_t w);
    data_t v;
    exp_x.delete();
    exp_y.delete();
    for (int i = 0; i < w; i++) begin
      v = sy + i;
      exp_x.push_back(sx);          exp_y.push_back(v);
      exp_x.push_back(sx + h - 1);  exp_y.push_back(v);
    end
    for (int j = 0; j < h; j++) begin
      v = sx + j;
      exp_x.push_back(v);  exp_y.push_back(sy);
      exp_x.push_back(v);  exp_y.push_back(sy + w - 1);
    end
  endtask

  // Pulse start, then scramble the inputs to show they were latched.
  task automatic start_seq(input data_t sx, input data_t sy, input data_t h, input data_t w);
    bus._start = 1'b1;
    bus.s_x = sx; bus.s_y = sy; bus.height = h; bus.width = w;
    tick;
    bus._start = 1'b0;
    bus.s_x = 32'h5A5A5A5A; bus.s_y = 32'hFFFF0000; bus.height = 3; bus.width = 9;
    chk("start_done_clear", bus._done, 1'b0);
    chk("start_valid_low", bus._valid, 1'b0);
  endtask

  // Check every pair of the expected stream, then the done/hold cycle.
  task automatic stream(input string tag, input int busy_at);
    for (int k = 0; k < exp_x.size(); k++) begin
      if (k == busy_at) begin
        bus._start = 1'b1;
        bus.s_x = 9; bus.s_y = 9; bus.height = 4; bus.width = 4;
      end
      tick;
      bus._start = 1'b0;
      chk($sformatf("%s_valid[%0d]", tag, k), bus._valid, 1'b1);
      chk($sformatf("%s_x[%0d]", tag, k), bus._out0, exp_x[k]);
      chk($sformatf("%s_y[%0d]", tag, k), bus._out1, exp_y[k]);
    end
    tick;
    chk({tag, "_end_valid"}, bus._valid, 1'b0);
    chk({tag, "_end_done"}, bus._done, 1'b1);
    chk({tag, "_end_hold_x"}, bus._out0, exp_x[exp_x.size()-1]);
    chk({tag, "_end_hold_y"}, bus._out1, exp_y[exp_y.size()-1]);
  endtask

  initial begin
    rst_n = 1'b0;
    bus._start = 1'b0;
    bus.s_x = '0; bus.s_y = '0; bus.height = '0; bus.width = '0;
    tick;
    tick;
    chk("rst_out0", bus._out0, 32'd0);
    chk("rst_out1", bus._out1, 32'd0);
    chk("rst_valid", bus._valid, 1'b0);
    chk("rst_done", bus._done, 1'b0);
    chk("rst_state", dut.state_q, ST_IDLE);
    rst_n = 1'b1;
    tick;
    chk("idle_valid", bus._valid, 1'b0);

    // Nominal 5x7 rectangle: 24 pairs, then held (27,23) for the window.
    build(23, 17, 5, 7);
    start_seq(23, 17, 5, 7);
    stream("nom", -1);
    for (int c = 0; c < 75; c++) begin
      tick;
      if (c % 15 == 0) begin
        chk("nom_win_valid", bus._valid, 1'b0);
        chk("nom_win_done", bus._done, 1'b1);
        chk("nom_win_x", bus._out0, 32'd27);
        chk("nom_win_y", bus._out1, 32'd23);
      end
    end

    // Restart with a 1x1 rectangle; a start mid-stream must be ignored.
    exp_x = '{32'd0, 32'd0, 32'd0, 32'd0};
    exp_y = '{32'd0, 32'd0, 32'd0, 32'd0};
    start_seq(0, 0, 1, 1);
    stream("one", 2);

    // Zero width: only the height loop runs.
    exp_x = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd7, 32'd7};
    exp_y = '{32'd10, 32'd9, 32'd10, 32'd9, 32'd10, 32'd9};
    start_seq(5, 10, 3, 0);
    stream("zw", -1);

    // Empty rectangle: done one cycle after start, outputs keep (7,9).
    start_seq(1, 2, 0, 0);
    tick;
    chk("empty_done", bus._done, 1'b1);
    chk("empty_hold_x", bus._out0, 32'd7);
    chk("empty_hold_y", bus._out1, 32'd9);
    for (int c = 0; c < 4; c++) begin
      chk("empty_valid", bus._valid, 1'b0);
      tick;
    end

    // Reset during the 5th pair, with a start on the same edge.
    build(23, 17, 5, 7);
    start_seq(23, 17, 5, 7);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("pre_rst_x[%0d]", k), bus._out0, exp_x[k]);
      chk($sformatf("pre_rst_y[%0d]", k), bus._out1, exp_y[k]);
    end
    rst_n = 1'b0;
    bus._start = 1'b1;
    tick;
    chk("mid_rst_out0", bus._out0, 32'd0);
    chk("mid_rst_out1", bus._out1, 32'd0);
    chk("mid_rst_valid", bus._valid, 1'b0);
    chk("mid_rst_done", bus._done, 1'b0);
    chk("mid_rst_state", dut.state_q, ST_IDLE);
    rst_n = 1'b1;
    bus._start = 1'b0;
    tick;
    chk("post_rst_valid", bus._valid, 1'b0);
    chk("post_rst_state", dut.state_q, ST_IDLE);
    start_seq(23, 17, 5, 7);
    stream("replay", -1);

    // Right/bottom arithmetic wraps at 2^31.
    exp_x = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    exp_y = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    start_seq(32'sh7FFFFFFF, 0, 2, 1);
    stream("wrap", -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
